sram_arbiter: RTL and testbench

Two-port round-robin arbiter that shares one `SRAM_Controller` front-end between the data-side requester (cache controller or Mem stage) and the instruction-fetch requester. It sits between those two requesters and the SRAM controller's golden-input interface. It latches the granted request, holds the controller enables for the full access, and returns per-requester `ready` and read data using the same freeze semantics the pipeline already uses.

---
 rtl/sram_arbiter_pkg.sv | 17 +
 rtl/rr_pick2.sv | 16 +
 rtl/sram_arbiter.sv | 126 ++++++++++++
 tb/tb_sram_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared widths and encodings for the two-port SRAM arbiter.
package sram_arbiter_pkg;

    localparam int ADDRESS_LEN = 32;
    localparam int WORD_LEN    = 32;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    typedef enum logic {
        ARB_OWN_D = 1'b0,
        ARB_OWN_I = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin selector: on a tie the port that was not
// granted last wins; bit 0 is the data port, bit 1 the fetch port.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (&req) begin
            gnt = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one SRAM controller between the data-side and
// instruction-fetch requesters; the granted request is latched for the access.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDRESS_LEN,
    parameter int DATA_W = WORD_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d_r_en,
    input  logic              d_w_en,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    input  logic              i_r_en,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    output logic              sram_read_en,
    output logic              sram_write_en,
    output logic [ADDR_W-1:0] sram_address,
    output logic [DATA_W-1:0] sram_write_data,
    input  logic [DATA_W-1:0] sram_read_data,
    input  logic              sram_ready
);

    arb_state_e        state_q, state_d;
    arb_owner_e        owner_q, owner_d;
    arb_owner_e        last_q, last_d;
    logic              op_wr_q, op_wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;

    logic       d_req, i_req;
    logic       busy, done, d_done, i_done;
    logic [1:0] gnt;

    assign d_req = d_r_en | d_w_en;
    assign i_req = i_r_en;

    rr_pick2 u_pick (
        .req  ({i_req, d_req}),
        .last (last_q == ARB_OWN_I),
        .gnt  (gnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ARB_IDLE;
            owner_q   <= ARB_OWN_D;
            last_q    <= ARB_OWN_I;
            op_wr_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            d_rdata_q <= '0;
            i_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            op_wr_q   <= op_wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            d_rdata_q <= d_rdata_d;
            i_rdata_q <= i_rdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        op_wr_d   = op_wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        d_rdata_d = d_rdata_q;
        i_rdata_d = i_rdata_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (|gnt) begin
                    owner_d = gnt[0] ? ARB_OWN_D : ARB_OWN_I;
                    last_d  = gnt[0] ? ARB_OWN_D : ARB_OWN_I;
                    // A simultaneous read+write from the data port is a write.
                    op_wr_d = gnt[0] & d_w_en;
                    addr_d  = gnt[0] ? d_addr : i_addr;
                    wdata_d = d_wdata;
                    state_d = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (sram_ready) begin
                    state_d = ARB_IDLE;
                    // Data for a requester that has already let go is dropped.
                    if (!op_wr_q && owner_q == ARB_OWN_D && d_req) begin
                        d_rdata_d = sram_read_data;
                    end
                    if (!op_wr_q && owner_q == ARB_OWN_I && i_req) begin
                        i_rdata_d = sram_read_data;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign busy   = (state_q == ARB_BUSY);
    // Reset masks completion so ready behaves as if the FSM were already idle.
    assign done   = busy & sram_ready & ~rst;
    assign d_done = done & (owner_q == ARB_OWN_D);
    assign i_done = done & (owner_q == ARB_OWN_I);

    assign sram_read_en    = busy & ~op_wr_q;
    assign sram_write_en   = busy & op_wr_q;
    assign sram_address    = addr_q;
    assign sram_write_data = wdata_q;

    assign d_ready = ~d_req | d_done;
    assign i_ready = ~i_req | i_done;
    assign d_rdata = d_done ? sram_read_data : d_rdata_q;
    assign i_rdata = i_done ? sram_read_data : i_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: behavioural arbiter model plus an SRAM model with
// configurable access latency, directed scenarios and a randomized phase.
module tb_sram_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          d_r_en = 1'b0, d_w_en = 1'b0, i_r_en = 1'b0;
    logic [AW-1:0] d_addr = '0, i_addr = '0, sram_address;
    logic [DW-1:0] d_wdata = '0, d_rdata, i_rdata, sram_write_data, sram_read_data;
    logic          d_ready, i_ready, sram_read_en, sram_write_en, sram_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk             (clk),
        .rst             (rst),
        .d_r_en          (d_r_en),
        .d_w_en          (d_w_en),
        .d_addr          (d_addr),
        .d_wdata         (d_wdata),
        .d_rdata         (d_rdata),
        .d_ready         (d_ready),
        .i_r_en          (i_r_en),
        .i_addr          (i_addr),
        .i_rdata         (i_rdata),
        .i_ready         (i_ready),
        .sram_read_en    (sram_read_en),
        .sram_write_en   (sram_write_en),
        .sram_address    (sram_address),
        .sram_write_data (sram_write_data),
        .sram_read_data  (sram_read_data),
        .sram_ready      (sram_ready)
    );

    // SRAM model: ready comes lat cycles after the enable rises.
    logic [DW-1:0] mem [0:1023];
    int lat = 5;
    int cnt = 0;
    assign sram_ready     = (sram_read_en | sram_write_en) && (cnt >= lat);
    assign sram_read_data = mem[sram_address[11:2]];
    always @(posedge clk) begin
        if (sram_write_en && sram_ready) mem[sram_address[11:2]] = sram_write_data;
        cnt <= (sram_read_en | sram_write_en) ? cnt + 1 : 0;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Behavioural model: one access in flight, owner, latched request, last winner.
    logic          chk_on = 1'b0;
    logic          m_busy = 1'b0, m_wr = 1'b0;
    int            m_owner = 0, m_last = 1;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] m_rd [2] = '{32'h0, 32'h0};
    logic          m_dq, m_iq, m_comp;
    int            m_pick;

    always @(negedge clk) begin
        if (chk_on) begin
            m_dq   = d_r_en | d_w_en;
            m_iq   = i_r_en;
            m_comp = m_busy && sram_ready && !rst;
            chk("sram_read_en", sram_read_en, m_busy && !m_wr);
            chk("sram_write_en", sram_write_en, m_busy && m_wr);
            chk("sram_address", sram_address, m_addr);
            chk("sram_write_data", sram_write_data, m_wdata);
            chk("d_ready", d_ready, !m_dq || (m_comp && m_owner == 0));
            chk("i_ready", i_ready, !m_iq || (m_comp && m_owner == 1));
            chk("d_rdata", d_rdata, (m_comp && m_owner == 0) ? sram_read_data : m_rd[0]);
            chk("i_rdata", i_rdata, (m_comp && m_owner == 1) ? sram_read_data : m_rd[1]);
            // Advance the model to what the next rising edge produces.
            if (rst) begin
                m_busy = 1'b0; m_wr = 1'b0; m_last = 1; m_owner = 0;
                m_addr = '0; m_wdata = '0; m_rd[0] = '0; m_rd[1] = '0;
            end else if (!m_busy) begin
                if (m_dq || m_iq) begin
                    if (m_dq && m_iq) m_pick = 1 - m_last;
                    else              m_pick = m_dq ? 0 : 1;
                    m_busy  = 1'b1;
                    m_owner = m_pick;
                    m_last  = m_pick;
                    m_wr    = (m_pick == 0) && d_w_en;
                    m_addr  = (m_pick == 0) ? d_addr : i_addr;
                    m_wdata = d_wdata;
                end
            end else if (sram_ready) begin
                if (!m_wr && ((m_owner == 0) ? m_dq : m_iq)) m_rd[m_owner] = sram_read_data;
                m_busy = 1'b0;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; d_r_en = 1'b0; d_w_en = 1'b0; i_r_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic d_access(input logic r, input logic w, input logic [31:0] a,
                            input logic [31:0] wd, output logic [31:0] rd, output int n);
        d_r_en = r; d_w_en = w; d_addr = a; d_wdata = wd;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!d_ready && n < 50);
        rd = d_rdata;
        @(posedge clk); #1;
        d_r_en = 1'b0; d_w_en = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((sram_read_en || sram_write_en) && n < 50);
        chk("idle_timeout", n < 50, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    logic [31:0] rd;
    int          n, gr, low;
    logic        pe, en, saw;
    int          lats [3] = '{5, 0, 2};

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[32'h100 >> 2] = 32'hDEADBEEF;
        mem[32'h040 >> 2] = 32'h0BADF00D;
        mem[32'h500 >> 2] = 32'h55550500;
        mem[32'h600 >> 2] = 32'h66660600;
        mem[32'h700 >> 2] = 32'h77770700;
        mem[32'h800 >> 2] = 32'h88880800;

        repeat (2) @(posedge clk);
        #1 chk_on = 1'b1;
        @(posedge clk); #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_ren", sram_read_en, 0);
        chk("rst_wen", sram_write_en, 0);
        chk("rst_addr", sram_address, 0);
        chk("rst_wdata", sram_write_data, 0);
        chk("rst_drdata", d_rdata, 0);
        chk("rst_irdata", i_rdata, 0);
        chk("rst_dready", d_ready, 1);
        chk("rst_iready", i_ready, 1);

        // 1: single data read
        do_reset();
        d_r_en = 1'b1; d_addr = 32'h100;
        @(negedge clk);
        chk("t1_idle_ren", sram_read_en, 0);
        chk("t1_idle_dready", d_ready, 0);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk("t1_ren", sram_read_en, 1);
            chk("t1_dready", d_ready, k == 6);
            chk("t1_iready", i_ready, 1);
            if (k == 6) chk("t1_rdata", d_rdata, 32'hDEADBEEF);
        end
        @(posedge clk); #1 d_r_en = 1'b0;
        @(negedge clk);
        chk("t1_ren_drop", sram_read_en, 0);
        chk("t1_rdata_hold", d_rdata, 32'hDEADBEEF);
        @(posedge clk); #1;

        // 2: simultaneous d write and i read right after reset
        do_reset();
        d_w_en = 1'b1; d_addr = 32'h200; d_wdata = 32'h12345678;
        i_r_en = 1'b1; i_addr = 32'h40;
        @(negedge clk);
        chk("t2_dready0", d_ready, 0);
        chk("t2_iready0", i_ready, 0);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk("t2_wen", sram_write_en, 1);
            chk("t2_waddr", sram_address, 32'h200);
            chk("t2_dready", d_ready, k == 6);
            chk("t2_iready_wait", i_ready, 0);
        end
        @(posedge clk); #1 d_w_en = 1'b0;
        @(negedge clk);
        chk("t2_gap_ren", sram_read_en, 0);
        chk("t2_gap_wen", sram_write_en, 0);
        @(negedge clk);
        chk("t2_i_ren", sram_read_en, 1);
        chk("t2_i_addr", sram_address, 32'h40);
        n = 0;
        while (!i_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t2_i_lat", n, 5);
        chk("t2_i_rdata", i_rdata, 32'h0BADF00D);
        @(posedge clk); #1 i_r_en = 1'b0;
        d_access(1'b1, 1'b0, 32'h200, 32'h0, rd, n);
        chk("t2_readback", rd, 32'h12345678);
        chk("t2_read_lat", n, 7);

        // 3: both held continuously, alternating grants with one idle cycle between
        do_reset();
        d_r_en = 1'b1; d_addr = 32'h500; i_r_en = 1'b1; i_addr = 32'h600;
        gr = 0; low = 0; pe = 1'b0;
        for (int c = 0; c < 80 && gr < 6; c++) begin
            @(negedge clk);
            en = sram_read_en | sram_write_en;
            if (en && !pe) begin
                if (gr > 0) chk("t3_gap", low, 1);
                chk("t3_order", sram_address, (gr % 2 == 0) ? 32'h500 : 32'h600);
                gr++;
            end
            low = en ? 0 : low + 1;
            pe = en;
        end
        chk("t3_grants", gr, 6);
        @(posedge clk); #1 d_r_en = 1'b0; i_r_en = 1'b0;
        wait_idle();

        // 4: read and write together on the data port is a write
        d_r_en = 1'b1; d_w_en = 1'b1; d_addr = 32'h300; d_wdata = 32'hA5A50300;
        n = 0; saw = 1'b0;
        do begin
            @(negedge clk);
            n++;
            chk("t4_no_ren", sram_read_en, 0);
            if (sram_write_en) saw = 1'b1;
        end while (!d_ready && n < 50);
        @(posedge clk); #1 d_r_en = 1'b0; d_w_en = 1'b0;
        chk("t4_wen_seen", saw, 1);
        chk("t4_mem", mem[32'h300 >> 2], 32'hA5A50300);

        // 5: reset in the third busy cycle of a fetch read
        i_r_en = 1'b1; i_addr = 32'h700;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("t5_iready_rst", i_ready, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("t5_ren_off", sram_read_en, 0);
        chk("t5_wen_off", sram_write_en, 0);
        chk("t5_irdata0", i_rdata, 0);
        chk("t5_iready_idle", i_ready, 0);
        n = 0;
        while (!i_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t5_restart_lat", n, 6);
        chk("t5_irdata", i_rdata, 32'h77770700);
        @(posedge clk); #1 i_r_en = 1'b0;

        // 6: data port drops its read mid-access
        d_access(1'b1, 1'b0, 32'h100, 32'h0, rd, n);
        chk("t6_prior", rd, 32'hDEADBEEF);
        d_r_en = 1'b1; d_addr = 32'h800;
        repeat (2) @(posedge clk);
        #1 d_r_en = 1'b0;
        for (int k = 2; k <= 6; k++) begin
            @(negedge clk);
            chk("t6_ren_held", sram_read_en, 1);
            chk("t6_dready", d_ready, 1);
        end
        @(negedge clk);
        chk("t6_ren_done", sram_read_en, 0);
        chk("t6_rdata_kept", d_rdata, 32'hDEADBEEF);
        @(posedge clk); #1;

        // Randomized traffic at several latencies, including zero-wait
        for (int p = 0; p < 3; p++) begin
            do_reset();
            lat = lats[p];
            for (int c = 0; c < 700; c++) begin
                @(posedge clk); #1;
                if ($urandom_range(0, 3) == 0) {d_r_en, d_w_en} = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 3) == 0) i_r_en = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 1) == 0) d_addr = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
                if ($urandom_range(0, 1) == 0) i_addr = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
                d_wdata = $urandom;
                rst = ($urandom_range(0, 99) == 0);
            end
            @(posedge clk); #1 rst = 1'b0;
        end
        do_reset();
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
